// File: rtl/pf_collision_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pf_collision_ctrl_pkg
// Description : Shared types and constants for the playfield collision
//               controller: FSM state encoding, playfield coordinate width,
//               default sprite box size and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pf_collision_ctrl_pkg;

  // Playfield coordinates are 9 bits and wrap modulo 512.
  localparam int PF_W      = 9;
  localparam int SPR_W_DEF = 8;
  localparam int SPR_H_DEF = 8;

  typedef logic [PF_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  // Counter width for a 0..n-1 range, never narrower than one bit so that a
  // 1-wide or 1-tall box still has a legal (constant zero) counter.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pf_collision_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pf_collision_ctrl_if
// Description : Signal bundle between the collision controller and its
//               surroundings (sync generator, player registers, playfield
//               lookup, renderer).
//   slave  : view taken by pf_collision_ctrl
//   master : view taken by the surrounding system / testbench
//   Signals: frame_start, player_x/y, vid_hpos/vpos, display_on, pf_gfx,
//            collision_clr (into controller); pf_hpos/vpos, vid_gfx,
//            collision, scan_done, scan_hit, conflict (out of controller).
// Revision    : 1.0 - initial release
// ============================================================================
interface pf_collision_ctrl_if;
  import pf_collision_ctrl_pkg::*;

  logic   frame_start;
  coord_t player_x;
  coord_t player_y;
  coord_t vid_hpos;
  coord_t vid_vpos;
  logic   display_on;
  logic   pf_gfx;
  coord_t pf_hpos;
  coord_t pf_vpos;
  logic   vid_gfx;
  logic   collision_clr;
  logic   collision;
  logic   scan_done;
  logic   scan_hit;
  logic   conflict;

  modport slave (
    input  frame_start, player_x, player_y, vid_hpos, vid_vpos,
           display_on, pf_gfx, collision_clr,
    output pf_hpos, pf_vpos, vid_gfx, collision, scan_done, scan_hit,
           conflict
  );

  modport master (
    output frame_start, player_x, player_y, vid_hpos, vid_vpos,
           display_on, pf_gfx, collision_clr,
    input  pf_hpos, pf_vpos, vid_gfx, collision, scan_done, scan_hit,
           conflict
  );

endinterface
`default_nettype wire

// File: rtl/pf_collision_ctrl_box_counter.sv
`default_nettype none
// ============================================================================
// Module      : pf_box_counter
// Description : Row-major dx/dy raster counter over an SPR_W x SPR_H box.
//   clk, reset : clock, asynchronous active-high reset
//   i_start    : zero both counters
//   i_step     : advance one pixel (dx fastest, wraps to next row)
//   o_dx/o_dy  : current offset inside the box
//   o_last     : current offset is the bottom-right pixel
// Revision    : 1.0 - initial release
// ============================================================================
module pf_box_counter
  import pf_collision_ctrl_pkg::*;
#(
  parameter int SPR_W = SPR_W_DEF,
  parameter int SPR_H = SPR_H_DEF,
  parameter int DXW   = cnt_width(SPR_W),
  parameter int DYW   = cnt_width(SPR_H)
) (
  input  wire logic           clk,
  input  wire logic           reset,
  input  wire logic           i_start,
  input  wire logic           i_step,
  output logic [DXW-1:0]      o_dx,
  output logic [DYW-1:0]      o_dy,
  output logic                o_last
);

  localparam logic [DXW-1:0] c_dx_last = DXW'(SPR_W - 1);
  localparam logic [DYW-1:0] c_dy_last = DYW'(SPR_H - 1);
  localparam logic [DXW-1:0] c_dx_one  = DXW'(1);
  localparam logic [DYW-1:0] c_dy_one  = DYW'(1);

  logic [DXW-1:0] r_dx;
  logic [DYW-1:0] r_dy;
  logic           w_dx_last;
  logic           w_dy_last;

  assign w_dx_last = (r_dx == c_dx_last);
  assign w_dy_last = (r_dy == c_dy_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dx <= '0;
      r_dy <= '0;
    end else if (i_start) begin
      r_dx <= '0;
      r_dy <= '0;
    end else if (i_step) begin
      if (w_dx_last) begin
        r_dx <= '0;
        r_dy <= w_dy_last ? '0 : (r_dy + c_dy_one);
      end else begin
        r_dx <= r_dx + c_dx_one;
      end
    end
  end

  assign o_dx   = r_dx;
  assign o_dy   = r_dy;
  assign o_last = w_dx_last & w_dy_last;

endmodule
`default_nettype wire

// File: rtl/pf_collision_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pf_collision_ctrl
// Description : Once per frame, probes every pixel of the player sprite box
//               against the playfield and reports a collision. Owns the
//               playfield lookup port: the renderer drives it by default,
//               the scanner takes it only while scanning.
//   clk, reset : clock, asynchronous active-high reset
//   bus.slave  : frame_start, player_x/y, vid_hpos/vpos, display_on, pf_gfx,
//                collision_clr in; pf_hpos/vpos, vid_gfx, collision,
//                scan_done, scan_hit, conflict out
// Revision    : 1.0 - initial release
// ============================================================================
module pf_collision_ctrl
  import pf_collision_ctrl_pkg::*;
#(
  parameter int SPR_W = SPR_W_DEF,
  parameter int SPR_H = SPR_H_DEF
) (
  input  wire logic            clk,
  input  wire logic            reset,
  pf_collision_ctrl_if.slave   bus
);

  localparam int DXW = cnt_width(SPR_W);
  localparam int DYW = cnt_width(SPR_H);

  state_t         r_state;
  state_t         w_state_nxt;
  coord_t         r_px;
  coord_t         r_py;
  logic           r_hit_acc;
  logic           r_collision;
  logic           r_last_hit;
  logic           r_conflict;

  logic [DXW-1:0] w_dx;
  logic [DYW-1:0] w_dy;
  logic           w_last;
  logic           w_start;
  logic           w_step;
  logic           w_in_scan;
  logic           w_in_report;

  pf_box_counter #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H),
    .DXW   (DXW),
    .DYW   (DYW)
  ) u_box_counter (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_start),
    .i_step  (w_step),
    .o_dx    (w_dx),
    .o_dy    (w_dy),
    .o_last  (w_last)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and counter control. frame_start outside IDLE is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.frame_start) begin
          w_start     = 1'b1;
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        w_step = 1'b1;
        if (w_last) w_state_nxt = ST_REPORT;
      end
      ST_REPORT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_in_scan   = (r_state == ST_SCAN);
  assign w_in_report = (r_state == ST_REPORT);

  // Position latch, hit accumulator and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_px        <= '0;
      r_py        <= '0;
      r_hit_acc   <= 1'b0;
      r_collision <= 1'b0;
      r_last_hit  <= 1'b0;
      r_conflict  <= 1'b0;
    end else begin
      if (w_start) begin
        r_px      <= bus.player_x;
        r_py      <= bus.player_y;
        r_hit_acc <= 1'b0;
      end else if (w_in_scan) begin
        // pf_gfx is combinational from the address driven this cycle.
        r_hit_acc <= r_hit_acc | bus.pf_gfx;
      end

      // A REPORT set takes priority over a simultaneous clear.
      if (w_in_report && r_hit_acc) r_collision <= 1'b1;
      else if (bus.collision_clr)   r_collision <= 1'b0;

      if (w_in_report) r_last_hit <= r_hit_acc;

      if (w_in_scan && bus.display_on) r_conflict <= 1'b1;
    end
  end

  // Lookup port mux; sums wrap naturally in 9 bits.
  always_comb begin
    bus.pf_hpos = bus.vid_hpos;
    bus.pf_vpos = bus.vid_vpos;
    if (w_in_scan) begin
      bus.pf_hpos = r_px + coord_t'(w_dx);
      bus.pf_vpos = r_py + coord_t'(w_dy);
    end
  end

  assign bus.vid_gfx   = bus.pf_gfx & bus.display_on & ~w_in_scan;
  assign bus.scan_done = w_in_report;
  // The fresh result is shown during REPORT, then held until the next REPORT.
  assign bus.scan_hit  = w_in_report ? r_hit_acc : r_last_hit;
  // Collision is visible already in the REPORT cycle that sets it.
  assign bus.collision = r_collision | (w_in_report & r_hit_acc);
  assign bus.conflict  = r_conflict;

endmodule
`default_nettype wire
